pipe_skid_stage: RTL and testbench

// - Parametrised pipeline stage register for the P5+ MIPS core; successor of the fixed EX/MEM latch.
// - Carries PC, instr and NUM_DATA data words of DATA_W bits.
// - Adds a valid/ready handshake with a 2-entry skid buffer, a flush that turns in-flight entries into bubbles, and a per-stage occupancy view.
// - Placed between any two stages (D/E, E/M, M/W), so upstream stalls are derived from in_ready instead of a global WE.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_skid_stage_entry.sv | 40 ++++
 rtl/pipe_skid_stage.sv | 136 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// Holds the nop encoding, the default bubble PC, and helpers that pack and
// unpack the {pc, instr} header of a stage payload. A full payload is laid
// out as {data, instr, pc}. The header therefore sits in the low 64 bits
// whatever NUM_DATA*DATA_W is, so the helpers need no width parameter.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned HDR_W            = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } stage_hdr_t;

    function automatic logic [HDR_W-1:0] pack_hdr(input logic [31:0] pc,
                                                  input logic [31:0] instr);
        return {instr, pc};
    endfunction

    function automatic stage_hdr_t unpack_hdr(input logic [HDR_W-1:0] hdr);
        return stage_hdr_t'(hdr);
    endfunction

endpackage

// File: rtl/pipe_skid_stage_entry.sv
// pipe_entry: one payload register with a valid bit.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        capture d and mark the entry valid
//   clear       drop the entry and turn the header into a bubble.
//               The data words are kept.
//   d           payload {data, instr, pc}
//   valid, q    registered valid bit and payload
// reset takes priority over clear, and clear takes priority over load.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 128,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] d,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] q
);

    localparam logic [HDR_W-1:0] BUBBLE_HDR = pack_hdr(RESET_PC, NOP_INSTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= {{(PAYLOAD_W-HDR_W){1'b0}}, BUBBLE_HDR};
        end else if (clear) begin
            valid          <= 1'b0;
            q[HDR_W-1:0]   <= BUBBLE_HDR;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: a pipeline stage register with a valid/ready handshake
// and a 2-entry skid buffer.
// The MAIN entry drives out_*. The SKID entry catches an entry that is
// accepted while MAIN is stalled. in_ready and occupancy come straight from
// flops.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_pc, in_instr, in_data      incoming entry (word k = [k*DATA_W +: DATA_W])
//   flush                         kills held entries and any offered entry
//   out_valid/out_ready           downstream handshake
//   out_pc, out_instr, out_data   head entry. While out_valid=0 this is a
//                                 bubble (pc RESET_PC, instr nop).
//   occupancy                     number of held entries (0..2)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
);

    localparam int unsigned DW = NUM_DATA * DATA_W;
    localparam int unsigned PW = HDR_W + DW;

    logic          accept;
    logic          issue;
    logic          main_valid;
    logic          skid_valid;
    logic          main_load;
    logic          main_clear;
    logic          skid_load;
    logic          skid_clear;
    logic          main_valid_nxt;
    logic          skid_valid_nxt;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    stage_hdr_t    head_hdr;

    assign accept     = in_valid & in_ready;
    assign issue      = main_valid & out_ready;
    assign in_payload = {in_data, pack_hdr(in_pc, in_instr)};

    // A held SKID entry always goes to MAIN before new input does. While SKID
    // is valid, in_ready is 0, so the two sources never compete.
    assign main_d = skid_valid ? skid_q : in_payload;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (main_valid) begin
            if (issue) begin
                if (skid_valid || accept) begin
                    main_load = 1'b1;
                end else begin
                    main_clear = 1'b1;
                end
                skid_clear = skid_valid;
            end else if (accept) begin
                skid_load = 1'b1;
            end
        end else if (accept) begin
            main_load = 1'b1;
        end
    end

    // Compute the next valid bits here so that in_ready and occupancy can be
    // registered. They then agree with the entry valids on every cycle.
    assign main_valid_nxt = main_load | (main_valid & ~main_clear);
    assign skid_valid_nxt = skid_load | (skid_valid & ~skid_clear);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            occupancy <= '0;
        end else begin
            in_ready  <= ~skid_valid_nxt;
            occupancy <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
        end
    end

    pipe_entry #(
        .PAYLOAD_W (PW),
        .RESET_PC  (RESET_PC)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_entry #(
        .PAYLOAD_W (PW),
        .RESET_PC  (RESET_PC)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign head_hdr  = unpack_hdr(main_q[HDR_W-1:0]);
    assign out_valid = main_valid;
    assign out_pc    = head_hdr.pc;
    assign out_instr = head_hdr.instr;
    assign out_data  = main_q[PW-1:HDR_W];

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_DATA = 2;
    localparam int unsigned DW       = DATA_W * NUM_DATA;
    localparam logic [31:0] RPC      = 32'h0000_3000;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_skid_stage #(
        .DATA_W   (DATA_W),
        .NUM_DATA (NUM_DATA),
        .RESET_PC (RPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Compare the outputs with the scoreboard head. An empty scoreboard means
    // a bubble is expected.
    task automatic check_outputs();
        int unsigned sz;
        sz = sb.size();
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'(sz < 2));
        chk("out_valid", 64'(out_valid), 64'(sz != 0));
        if (sz != 0) begin
            chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
            chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
            chk("out_data", out_data, sb[0].data);
        end else begin
            chk("bubble_pc", 64'(out_pc), 64'(RPC));
            chk("bubble_instr", 64'(out_instr), 64'h0);
        end
    endtask

    // One clock cycle: drive the inputs just after posedge, check at negedge,
    // then advance the scoreboard with the transfers that happen at the next
    // posedge.
    task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic [DW-1:0] d);
        logic acc;
        logic iss;
        ent_t e;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = pc;
        in_instr  = instr;
        in_data   = d;
        @(negedge clk);
        check_outputs();
        acc = in_valid & in_ready;
        iss = out_valid & out_ready;
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (iss && sb.size() != 0) void'(sb.pop_front());
            if (acc) begin
                e.pc    = pc;
                e.instr = instr;
                e.data  = d;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ordy, input logic [31:0] pc);
        step(1'b0, 1'b0, 1'b1, ordy, pc, {16'hA5C3, pc[15:0]}, {~pc, pc});
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, ordy, 32'hDEAD_BEEF, 32'hFFFF_FFFF, '1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_pc", 64'(out_pc), 64'h3000);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // Streaming with out_ready held high
        for (int i = 0; i < 4; i++) send(1'b1, RPC + 32'(4 * i));
        idle(1'b1);
        idle(1'b1);

        // Skid: A is stalled, B goes to the skid entry, then both drain in order
        send(1'b1, 32'h3000);
        send(1'b0, 32'h3004);
        idle(1'b0);
        chk("skid_occ_full", 64'(occupancy), 64'h2);
        chk("skid_in_ready_low", 64'(in_ready), 64'h0);
        chk("skid_hold_a", 64'(out_pc), 64'h3000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full with C offered. C must never appear.
        send(1'b0, 32'h3000);
        send(1'b0, 32'h3004);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h1234_5678, 64'h1);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_out_instr", 64'(out_instr), 64'h0);
        chk("flush_occ", 64'(occupancy), 64'h0);
        idle(1'b1);

        // Flush with one entry held. The offered entry is dropped even though in_ready=1.
        send(1'b0, 32'h3010);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3014, 32'h8765_4321, 64'h2);
        idle(1'b1);

        // Reset mid-stall, then the first entry after reset has 1-cycle latency
        send(1'b0, 32'h3020);
        send(1'b0, 32'h3024);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h3028, 32'h0, 64'h3);
        chk("rst2_out_pc", 64'(out_pc), 64'h3000);
        chk("rst2_out_data", out_data, 64'h0);
        chk("rst2_in_ready", 64'(in_ready), 64'h1);
        send(1'b1, 32'h3030);
        chk("post_rst_latency", 64'(out_pc), 64'h3030);
        idle(1'b1);

        // Random valid/ready with an occasional flush
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, {$urandom, $urandom});
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
